mux_rr_arbiter: RTL

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

---
 rtl/mux_arb_pkg.sv | 38 +++
 rtl/mux_4x1.sv | 23 ++
 rtl/mux_rr_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Index of the first set request bit, searching upward from ptr and wrapping.
  // The caller guarantees req is non-zero, so the ptr fallback never wins.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   ptr);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] found;
    logic             hit;
    found = ptr;
    hit   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + SEL_W'(k);
      if (!hit && req[idx]) begin
        found = idx;
        hit   = 1'b1;
      end
    end
    return found;
  endfunction

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] g;
    g      = '0;
    g[idx] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/mux_4x1.sv
// Plain 4:1 single-bit multiplexer, select = {s1,s0}.
module mux_4x1 (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic s1,
  input  logic s0,
  output logic y
);

  // Select one of four inputs.
  always_comb begin
    y = 1'b0;
    case ({s1, s0})
      2'b00:   y = i0;
      2'b01:   y = i1;
      2'b10:   y = i2;
      default: y = i3;
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Four-requester round-robin arbiter driving a 4:1 mux with a registered output.
// Optional feature macro: MUX_ARB_TIMEOUT_EN adds a hold counter that forces a
// grantee off the mux after MAX_HOLD busy cycles and pulses `timeout`.
//
// state | meaning
// IDLE  | no grant; arbitrate among req starting at ptr
// BUSY  | one requester owns the mux until done, req drop, or hold limit
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  input  logic               i0,
  input  logic               i1,
  input  logic               i2,
  input  logic               i3,
  output logic [NUM_REQ-1:0] grant,
  output logic               s1,
  output logic               s0,
  output logic               valid,
  output logic               y
`ifdef MUX_ARB_TIMEOUT_EN
  ,
  output logic               timeout
`endif
);

  arb_state_e         state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               y_q;
  logic               mux_y;
  logic               rel_c;
  logic               limit_c;
  logic [SEL_W-1:0]   pick_c;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q, timeout_d;

  // Busy-cycle counter; the last allowed busy cycle sees HOLD_LAST.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    limit_c    = 1'b0;
    if (state_q == IDLE) begin
      hold_cnt_d = '0;
    end else begin
      hold_cnt_d = hold_cnt_q + 8'd1;
      limit_c    = (hold_cnt_q == HOLD_LAST);
      // A normal release in the same cycle as the limit is not a timeout.
      timeout_d  = limit_c && !rel_c;
    end
  end

  // Hold counter and timeout pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic [7:0] max_hold_unused;
  assign max_hold_unused = 8'(MAX_HOLD);
  assign limit_c = 1'b0;
`endif

  // Next-state, arbitration and release decision.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    rel_c   = 1'b0;
    pick_c  = rr_pick(req, ptr_q);
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = BUSY;
          sel_d   = pick_c;
          grant_d = to_onehot(pick_c);
        end else begin
          sel_d   = '0;
          grant_d = '0;
        end
      end
      BUSY: begin
        rel_c = done || !req[sel_q];
        if (rel_c || limit_c) begin
          state_d = IDLE;
          ptr_d   = sel_q + SEL_W'(1);
          sel_d   = '0;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        grant_d = '0;
      end
    endcase
  end

  // State, pointer, select and grant registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
    end
  end

  mux_4x1 u_mux (
    .i0 (i0),
    .i1 (i1),
    .i2 (i2),
    .i3 (i3),
    .s1 (sel_q[1]),
    .s0 (sel_q[0]),
    .y  (mux_y)
  );

  // Output register: forced low whenever no grant was active last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= 1'b0;
    end else begin
      y_q <= (state_q == BUSY) ? mux_y : 1'b0;
    end
  end

  assign grant = grant_q;
  assign s1    = sel_q[1];
  assign s0    = sel_q[0];
  assign valid = (state_q == BUSY);
  assign y     = y_q;

endmodule
